// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream
//   Read-side controller for a synchronous FIFO. Pops words using rd/empty/dout
//   (read data returns one clock after the strobe) and re-presents them as a
//   valid/ready stream through a 2-entry skid buffer. It sustains one word per
//   clock while the consumer is ready, and it never over-reads, drops or
//   duplicates a word.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   en          1 = issue FIFO reads; 0 = stop issuing, finish in-flight work
//   fifo_empty  FIFO empty flag
//   fifo_rd     FIFO read strobe (combinational)
//   fifo_dout   FIFO read data, valid one clock after fifo_rd
//   m_valid     output word available
//   m_ready     consumer accepts; a transfer is m_valid & m_ready at posedge
//   m_data      output word, taken from the head of the skid buffer (registered)
//   busy        read in flight or skid buffer non-empty
//   word_cnt    completed output transfers, wraps modulo 2^CNT_WIDTH
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  logic [1:0]            occ_q;   // buffer entries: 0, 1 or 2
  logic                  infl_q;  // fifo_rd was issued last cycle
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic       pop;
  logic [2:0] pending;

  assign pop = (occ_q != 2'd0) & m_ready;

  // Entries that will be held once this cycle's pop and the in-flight word
  // settle. Keeping it below 2 before issuing guarantees every returning word
  // has a free slot. pop implies occ_q >= 1, so this never underflows.
  assign pending = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};

  // Reset also blocks reads, so no word is popped and then lost.
  assign fifo_rd = ~rst & en & ~fifo_empty & (pending < 3'd2);

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = head_q;
  assign busy     = infl_q | (occ_q != 2'd0);
  assign word_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      infl_q <= fifo_rd;
      if (pop) begin
        cnt_q <= cnt_q + 1'b1;
      end
      case ({pop, infl_q})
        // Pop and capture together: occupancy is unchanged.
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= fifo_dout;
          end else begin
            head_q <= fifo_dout;
          end
        end
        2'b10: begin
          occ_q <= occ_q - 2'd1;
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
          end
        end
        // Capture only. The issue rule rules out occ_q == 2 here.
        2'b01: begin
          occ_q <= occ_q + 2'd1;
          if (occ_q == 2'd0) begin
            head_q <= fifo_dout;
          end else begin
            tail_q <= fifo_dout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream
//   Self-checking bench for fifo_rd_stream, using a behavioural FIFO whose read
//   data returns one clock after the strobe. Inputs change 1 time unit after
//   posedge. Outputs are sampled on negedge, where the values stay stable up to
//   the next active edge. The counter width is 3 so that wrap-around shows up.
module tb_fifo_rd_stream;

  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [DW-1:0] fifo_dout = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy;
  logic [CW-1:0] word_cnt;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO model.
  logic [DW-1:0] mem [0:1023];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  logic          rd_smp = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rd_smp) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: everything sampled here holds until the next posedge.
  logic [DW-1:0] rx[$];
  int            rd_pulses = 0;
  int            viol      = 0;

  always @(negedge clk) begin
    rd_smp <= fifo_rd;
    if (m_valid && m_ready) rx.push_back(m_data);
    if (fifo_rd) rd_pulses <= rd_pulses + 1;
    if (fifo_rd && fifo_empty) viol <= viol + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_seq(input string name, input int base, input int start, input int n);
    check({name, " count"}, rx.size() - base, n);
    for (int k = 0; k < n && base + k < rx.size(); k++) begin
      check(name, rx[base+k], start + k);
    end
  endtask

  task automatic load(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = start + i;
      wr_ptr++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Waits until rx holds target words or the cycle limit expires.
  task automatic wait_rx(input string name, input int target, input int limit);
    int c = 0;
    while (rx.size() < target && c < limit) begin
      tick();
      c++;
    end
    check({name, " timeout"}, (rx.size() >= target), 1);
  endtask

  typedef struct {
    logic          rst;
    logic          en;
    logic          rdy;
    logic          x_rd;
    logic          x_v;
    logic [DW-1:0] x_d;
    logic          x_b;
    logic [CW-1:0] x_c;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int p0;
    int n0;
    int unstable;

    // Reset held over 3 table rows, then a stream of 1..8.
    //          rst   en    rdy   rd    v     data busy cnt
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 3'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 3'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 3'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b1, 3'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b1, 3'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1, 3'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b1, 3'd3};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b1, 3'd4};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6, 1'b1, 3'd5};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7, 1'b1, 3'd6};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8, 1'b1, 3'd7};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8, 1'b0, 3'd0};

    rst     = 1'b1;
    en      = 1'b1;
    m_ready = 1'b1;
    load(1, 8);
    tick();

    // Reset behaviour and full-rate streaming.
    base = rx.size();
    p0   = rd_pulses;
    for (int i = 0; i < 14; i++) begin
      rst     = tbl[i].rst;
      en      = tbl[i].en;
      m_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("row%0d fifo_rd", i), fifo_rd, tbl[i].x_rd);
      check($sformatf("row%0d m_valid", i), m_valid, tbl[i].x_v);
      check($sformatf("row%0d m_data", i), m_data, tbl[i].x_d);
      check($sformatf("row%0d busy", i), busy, tbl[i].x_b);
      check($sformatf("row%0d word_cnt", i), word_cnt, tbl[i].x_c);
      tick();
    end
    check("stream rd pulses", rd_pulses - p0, 8);
    check_seq("stream order", base, 1, 8);

    // Backpressure: two reads fill the skid buffer, then the head holds.
    do_reset();
    load(1, 8);
    m_ready  = 1'b0;
    base     = rx.size();
    p0       = rd_pulses;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid && m_data !== 1) unstable++;
      tick();
    end
    check("stall rd pulses", rd_pulses - p0, 2);
    check("stall head stable", unstable, 0);
    @(negedge clk);
    check("stall m_valid", m_valid, 1);
    check("stall m_data", m_data, 1);
    tick();
    m_ready = 1'b1;
    wait_rx("stall drain", base + 8, 100);
    check_seq("stall order", base, 1, 8);
    tick();
    check("stall busy end", busy, 0);

    // Pseudo-random stalls over 0..99.
    do_reset();
    load(0, 100);
    base = rx.size();
    for (int c = 0; c < 2000 && rx.size() < base + 100; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    check_seq("random order", base, 0, 100);
    check("random word_cnt", word_cnt, 100 % 8);
    check("no read while empty", viol, 0);

    // en gating after three delivered words.
    do_reset();
    load(1, 8);
    base = rx.size();
    wait_rx("en first3", base + 3, 50);
    en = 1'b0;
    n0 = rx.size();
    p0 = rd_pulses;
    repeat (5) tick();
    check("en low no reads", rd_pulses - p0, 0);
    check("en low extra <= 2", (rx.size() - n0 <= 2), 1);
    en = 1'b1;
    wait_rx("en resume", base + 8, 100);
    check_seq("en order", base, 1, 8);

    // Counter wrap, then reset while the buffer is full.
    do_reset();
    load(100, 14);
    base = rx.size();
    wait_rx("wrap 10", base + 10, 100);
    check("wrap word_cnt", word_cnt, 2);
    m_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("full m_valid", m_valid, 1);
    check("full m_data", m_data, 110);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);
    check("rst m_valid", m_valid, 0);
    check("rst busy", busy, 0);
    check("rst word_cnt", word_cnt, 0);
    check("rst m_data", m_data, 0);
    check("rst fifo_rd", fifo_rd, 0);
    check_seq("wrap order", base, 100, 10);
    check("final no read while empty", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
